// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_WORD_BYTES = 4;

    // Mid-bit counter value around which the three-sample vote is centred.
    function automatic int uart_mid(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Synchronizer, byte FSM and 3-sample majority vote; byte strobe on the stop decision cycle, error pulses one cycle later.
// UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_valid,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      rx_idle
);

    localparam int MID = uart_mid(CLKS_PER_BIT);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_MIDM = CW'(MID - 1);
    localparam logic [CW-1:0] C_MID  = CW'(MID);
    localparam logic [CW-1:0] C_MIDP = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    uart_rx_state_t            state, state_n;
    logic                      rx_m, rx_s;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      s0, s1, vote, decide, bit_end, frame_det, par_bad;

    assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign decide    = (cnt == C_MIDP);
    assign bit_end   = (cnt == C_LAST);
    assign byte_data = shreg;
    assign rx_idle   = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        frame_det  = 1'b0;
        case (state)
            ST_IDLE:  if (!rx_s) state_n = ST_START;
            // A start bit that is high again at mid-bit was a glitch.
            ST_START: if (cnt == C_MID && rx_s) state_n = ST_IDLE;
                      else if (bit_end)         state_n = ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:   if (bit_end && bit_idx == 3'(UART_DATA_BITS - 1)) state_n = ST_PARITY;
            ST_PARITY: if (bit_end) state_n = ST_STOP;
`else
            ST_DATA:   if (bit_end && bit_idx == 3'(UART_DATA_BITS - 1)) state_n = ST_STOP;
`endif
            ST_STOP: if (decide) begin
                if (vote) begin
                    state_n    = ST_IDLE;
                    byte_valid = !par_bad;
                end else begin
                    state_n   = ST_BREAK;
                    frame_det = 1'b1;
                end
            end
            ST_BREAK: if (rx_s) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            cnt <= (state_n != state || bit_end) ? '0 : cnt + 1'b1;
            if (cnt == C_MIDM) s0 <= rx_s;
            if (cnt == C_MID)  s1 <= rx_s;
            if (state == ST_DATA && decide) shreg <= {vote, shreg[UART_DATA_BITS-1:1]};
            if (state != ST_DATA) bit_idx <= '0;
            else if (bit_end)     bit_idx <= bit_idx + 3'd1;
            frame_err <= frame_det;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == ST_PARITY && decide) begin
                par_bad    <= vote ^ (^shreg);
                parity_err <= vote ^ (^shreg);
            end
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/uart_word_rx.sv
// Packs four received bytes (little-endian) into a word behind a valid/ready register; drops and flags overrun when full.
// Partial words are discarded after TIMEOUT_BITS idle bit periods; UART_RX_PARITY_EN is handled in uart_rx_byte.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun,
    output logic        timeout
);

    localparam int SHADOW_W = UART_DATA_BITS * (UART_WORD_BYTES - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic [UART_DATA_BITS-1:0] byte_data;
    logic                      byte_valid, rx_idle, word_done, timeout_hit;
    logic [1:0]                idx;
    logic [SHADOW_W-1:0]       shadow;
    logic [31:0]               idle_cnt;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_idle    (rx_idle)
    );

    assign word_done   = byte_valid && (idx == 2'(UART_WORD_BYTES - 1));
    assign timeout_hit = (idx != 2'd0) && rx_idle && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            shadow <= '0;
        end else if (frame_err || parity_err || timeout_hit) begin
            idx <= '0;
        end else if (byte_valid) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    shadow[7:0]   <= byte_data;
                2'd1:    shadow[15:8]  <= byte_data;
                2'd2:    shadow[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // Idle counter only runs while a partial word is waiting in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (timeout_hit || idx == 2'd0 || !rx_idle) idle_cnt <= '0;
            else                                        idle_cnt <= idle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!word_valid || word_ready) begin
                    word_data  <= {byte_data, shadow};
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed + randomized bench for uart_word_rx with a byte-level reference model.
module tb_uart_word_rx;

    localparam int CPB = 16;
    localparam int TOB = 8;
    localparam int MID = CPB / 2;

    logic        clk = 1'b0;
    logic        reset, rx, word_ready;
    logic [31:0] word_data;
    logic        word_valid, frame_err, parity_err, overrun, timeout;

    always #5 clk = ~clk;

    uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Pulse counters (rising edges and high cycles), accepted-word log, stability watch.
    int fe_n = 0, fe_h = 0, pe_n = 0, pe_h = 0, ov_n = 0, ov_h = 0, to_n = 0, to_h = 0;
    int unstable = 0, rise_cyc = 0;
    logic fe_q = 0, pe_q = 0, ov_q = 0, to_q = 0, wv_q = 0, held_v = 0;
    logic [31:0] held = 0;
    logic [31:0] acc_q[$];

    always @(negedge clk) begin
        if (frame_err)  begin fe_h++; if (!fe_q) fe_n++; end
        if (parity_err) begin pe_h++; if (!pe_q) pe_n++; end
        if (overrun)    begin ov_h++; if (!ov_q) ov_n++; end
        if (timeout)    begin to_h++; if (!to_q) to_n++; end
        if (word_valid && !wv_q) rise_cyc = cyc;
        if (word_valid && word_ready) acc_q.push_back(word_data);
        if (held_v && word_data !== held) unstable++;
        held_v = word_valid && !word_ready;
        held   = word_data;
        fe_q = frame_err; pe_q = parity_err; ov_q = overrun; to_q = timeout; wv_q = word_valid;
    end

    int n_tests = 0, n_fail = 0;
    int s_fe, s_feh, s_pe, s_peh, s_ov, s_ovh, s_to, s_toh, s_acc, stop_edge;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_fe = fe_n; s_feh = fe_h; s_pe = pe_n; s_peh = pe_h;
        s_ov = ov_n; s_ovh = ov_h; s_to = to_n; s_toh = to_h;
        s_acc = acc_q.size();
    endtask

    function automatic logic [31:0] got_word(input int k);
        return (acc_q.size() > k) ? acc_q[k] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] flags_since();
        return 32'((fe_n - s_fe) + (pe_n - s_pe) + (ov_n - s_ov) + (to_n - s_to));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v = 1'b1);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rx = d[i]; tick(CPB); end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip; tick(CPB);
`endif
        stop_edge = cyc;
        rx = stop_v; tick(CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] ew;
        logic [7:0]  b;
        int          off;

        reset = 1'b1; rx = 1'b1; word_ready = 1'b1;
        tick(3);
        check("rst_valid", {31'd0, word_valid}, 0);
        check("rst_data", word_data, 0);
        check("rst_pulses", {28'd0, frame_err, parity_err, overrun, timeout}, 0);
        reset = 1'b0;
        tick(2 * CPB);

        // Basic word and handoff latency.
        snap();
        send_word(32'h1234_5678);
        tick(2 * CPB);
        check("t1_nwords", 32'(acc_q.size() - s_acc), 1);
        check("t1_word", got_word(s_acc), 32'h1234_5678);
        off = rise_cyc - stop_edge;
        check("t1_latency", {31'd0, off >= MID + 4 && off <= MID + 6}, 1);
        check("t1_flags", flags_since(), 0);

        // Short low glitch is ignored; a word still follows.
        snap();
        rx = 1'b0; tick(4); rx = 1'b1; tick(3 * CPB);
        check("glitch_nwords", 32'(acc_q.size() - s_acc), 0);
        check("glitch_flags", flags_since(), 0);
        ew = $urandom;
        send_word(ew);
        tick(2 * CPB);
        check("glitch_word", got_word(s_acc), ew);

        // Framing error on the 2nd byte clears the partial word.
        snap();
        send_byte(8'h5A);
        send_byte(8'h99, 1'b0);
        rx = 1'b1; tick(2 * CPB);
        send_word(32'hDEAD_BEEF);
        tick(2 * CPB);
        check("frame_pulses", 32'(fe_n - s_fe), 1);
        check("frame_width", 32'(fe_h - s_feh), 1);
        check("frame_nwords", 32'(acc_q.size() - s_acc), 1);
        check("frame_word", got_word(s_acc), 32'hDEAD_BEEF);

        // Overrun while the consumer stalls.
        word_ready = 1'b0;
        snap();
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        tick(2 * CPB);
        check("ovr_pulses", 32'(ov_n - s_ov), 1);
        check("ovr_width", 32'(ov_h - s_ovh), 1);
        check("ovr_data", word_data, 32'h1111_1111);
        check("ovr_valid", {31'd0, word_valid}, 1);
        check("ovr_noaccept", 32'(acc_q.size() - s_acc), 0);
        word_ready = 1'b1;
        tick(1);
        check("ovr_drop_valid", {31'd0, word_valid}, 0);
        tick(CPB);
        check("ovr_one_accept", 32'(acc_q.size() - s_acc), 1);
        check("ovr_accept_word", got_word(s_acc), 32'h1111_1111);

        // Partial word discarded after the idle timeout.
        snap();
        send_byte(8'h55);
        send_byte(8'h66);
        rx = 1'b1; tick((TOB + 1) * CPB);
        check("to_pulses", 32'(to_n - s_to), 1);
        check("to_width", 32'(to_h - s_toh), 1);
        check("to_nwords", 32'(acc_q.size() - s_acc), 0);
        send_word(32'h0102_0304);
        tick(2 * CPB);
        check("to_word", got_word(s_acc), 32'h0102_0304);

        // Reset in the middle of a frame loses the partial word.
        send_byte(8'h01);
        send_byte(8'h02);
        rx = 1'b0; tick(3 * CPB);
        reset = 1'b1; rx = 1'b1; tick(2);
        check("midrst_valid", {31'd0, word_valid}, 0);
        reset = 1'b0; tick(2 * CPB);
        snap();
        ew = $urandom;
        send_word(ew);
        tick(2 * CPB);
        check("midrst_nwords", 32'(acc_q.size() - s_acc), 1);
        check("midrst_word", got_word(s_acc), ew);

        // Random words with random inter-byte gaps below the timeout.
        snap();
        for (int w = 0; w < 6; w++) begin
            ew = 32'd0;
            for (int k = 0; k < 4; k++) begin
                b  = 8'($urandom);
                ew = ew + (32'(b) << (8 * k));
                send_byte(b);
                rx = 1'b1;
                tick($urandom_range(0, 3) * CPB);
            end
            exp_q.push_back(ew);
        end
        tick(2 * CPB);
        check("rand_nwords", 32'(acc_q.size() - s_acc), 6);
        for (int w = 0; w < 6; w++) check($sformatf("rand_word%0d", w), got_word(s_acc + w), exp_q[w]);
        check("rand_flags", flags_since(), 0);

`ifdef UART_RX_PARITY_EN
        snap();
        par_flip = 1'b1;
        send_byte(8'hA5);
        par_flip = 1'b0;
        tick(CPB);
        send_word(32'h0D0C_0B0A);
        tick(2 * CPB);
        check("par_pulses", 32'(pe_n - s_pe), 1);
        check("par_width", 32'(pe_h - s_peh), 1);
        check("par_nwords", 32'(acc_q.size() - s_acc), 1);
        check("par_word", got_word(s_acc), 32'h0D0C_0B0A);
`else
        check("par_never", 32'(pe_h), 0);
`endif
        check("data_stable", 32'(unstable), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial-to-word receiver that sits directly upstream of the memory communication controller on the `mem_rx` path. It oversamples the asynchronous `rx` line, decodes 8N1 frames (8E1 when parity is compiled in), and packs four consecutive bytes, little-endian, into a 32-bit word. The word is presented to the consumer over a valid/ready handshake. Framing, parity, overrun and inter-byte timeout conditions are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 87, clock cycles per bit period; must be ≥ 4.
- `TIMEOUT_BITS`, 32, idle bit periods after which a partial word is discarded.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `word_data` out 32: assembled word; first received byte in [7:0].
- `word_valid` out 1: `word_data` holds an unconsumed word.
- `word_ready` in 1: consumer accepts the word when `word_valid && word_ready` at a rising edge.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on a parity mismatch; tied 0 without the macro.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `timeout` out 1: one-cycle pulse when a partial word is discarded on timeout.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Byte FSM states and transitions:
  - IDLE: on synced `rx` == 0 → START.
  - START: at MID = CLKS_PER_BIT/2, `rx` still 0 → DATA; otherwise the low was a glitch → IDLE, no flags.
  - DATA: 8 bits, LSB first → PARITY (macro) or STOP.
  - PARITY: → STOP.
  - STOP: → IDLE; on stop error → BREAK.
  - BREAK: → IDLE once synced `rx` is 1.
- Bit sampling: majority vote of 3 samples taken at bit-counter values MID-1, MID, MID+1. The decision is made at MID+1.
- Stop sampled 0: `frame_err` pulses, the byte is discarded, the partial word (byte index) is cleared, and the FSM enters BREAK.
- Good byte: written to lane [8*idx+7 : 8*idx] of the shadow register, and idx increments. When idx wraps from 3 to 0, the word is complete.
- Completed word handoff:
  - `word_valid` == 0: load the output register and set `word_valid`.
  - `word_valid` == 1 with `word_ready` == 1 in the same cycle: the old word is consumed, the new word is loaded, and `word_valid` stays 1.
  - `word_valid` == 1 with `word_ready` == 0: the new word is dropped, `overrun` pulses, and the old word is unchanged.
- `word_data` is stable while `word_valid` is high and not yet accepted. Deassertion on acceptance takes effect the next cycle.
- Timeout: while idx ≠ 0 and the FSM is in IDLE, an idle counter runs. After TIMEOUT_BITS × CLKS_PER_BIT cycles, idx clears and `timeout` pulses. The counter restarts on every start detection.

## Timing
- Reset: `word_data`=0, `word_valid`=0, all error pulses 0, FSM=IDLE, idx=0.
- Reset mid-frame aborts reception immediately. The partial word is lost.
- Synchronizer latency: 2 cycles.
- `word_valid` rises on the cycle after the stop-bit decision (MID+1 of the stop bit) of the 4th byte.
- Error pulses are registered and fire on the cycle after the deciding sample.
- A new start bit is accepted on the first cycle after STOP returns to IDLE. Back-to-back frames are supported.

## Configuration
- `UART_RX_PARITY_EN` defined: one even-parity bit follows the data bits. On mismatch, `parity_err` pulses, the byte is discarded, idx clears, and reception continues to STOP normally.
- `UART_RX_PARITY_EN` undefined: 8N1 framing, the PARITY state is absent, and `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - `UART_DATA_BITS` = 8 and `UART_WORD_BYTES` = 4;
  - a function computing MID from CLKS_PER_BIT.
- Sub-module `uart_rx_byte` contains the synchronizer, byte FSM, oversampling and vote. It emits `byte_data`, `byte_valid`, `frame_err` and `parity_err` pulses.
- The top level contains the packer, handshake and timeout logic.

## Test plan
- CLKS_PER_BIT=16; send 0x78, 0x56, 0x34, 0x12 back-to-back → `word_data`=0x12345678. `word_valid` rises 1 cycle after the 4th stop decision; no flags.
- `rx` low for 4 cycles, then high → no byte, no flags, FSM back in IDLE. A following word decodes correctly.
- 2nd byte sent with stop bit 0 → `frame_err` is a 1-cycle pulse and idx clears. The next 4 bytes 0xEF, 0xBE, 0xAD, 0xDE give 0xDEADBEEF.
- Hold `word_ready`=0 and send 8 bytes forming 0x11111111 then 0x22222222 → exactly one `overrun` pulse and `word_data` stays 0x11111111. Raise `word_ready` → one accept, then `word_valid` drops.
- Send 2 bytes, then idle (TIMEOUT_BITS+1) bit periods → one `timeout` pulse. Then 4 bytes 0x04, 0x03, 0x02, 0x01 → 0x01020304.
- With `UART_RX_PARITY_EN`: byte 0xA5 with parity bit 1 (wrong; even parity requires 0) → `parity_err` pulse, idx=0. Correct parity → normal word.
